// File: rtl/serial_sum_collector_if.sv
// Serial-side and parallel-side handshake bundle of the sum collector.
// slave: collector view; master: adder/consumer (bench) view.
interface serial_sum_collector_if #(
  parameter int N = 4
);
  logic         s_valid;
  logic         s_bit;
  logic         s_first;
  logic         s_cout;
  logic         s_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out_data;

  modport slave (
    input  s_valid, s_bit, s_first, s_cout,
    output s_ready,
    output out_valid, out_data,
    input  out_ready
  );

  modport master (
    output s_valid, s_bit, s_first, s_cout,
    input  s_ready,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/serial_sum_collector.sv
// Reassembles LSB-first serial sums + carry into N+1 bit words, FIFO'd out.
// Ports: clk, rst (async active-low), bus (slave), count, frame_err, busy.
module serial_sum_collector #(
  parameter int N     = 4,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  serial_sum_collector_if.slave bus,
  output logic [CW-1:0] count,
  output logic          frame_err,
  output logic          busy
);

  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    ASSEMBLE
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nx;
  logic [N-1:0]    r_shift;
  logic [N-1:0]    w_shift_nx;
  logic            r_ferr;
  logic            w_ferr_nx;

  logic [N:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_last;
  logic            w_acc;
  logic            w_done;
  logic            w_push;
  logic            w_pop;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_last = (r_cnt == CNTW'(N - 1));

  // Only the word-completing bit can need FIFO space, and readiness is
  // judged on registered state alone so out_ready never reaches s_ready.
  assign bus.s_ready = !(w_last && w_full);
  assign w_acc       = bus.s_valid && bus.s_ready;
  assign w_pop       = (r_count != '0) && bus.out_ready;
  assign w_push      = w_done;

  // New bit enters at the MSB; an s_first bit restarts the word.
  always_comb begin
    w_shift_nx = r_shift;
    if (w_acc) begin
      w_shift_nx[N-1] = bus.s_bit;
      for (int i = 0; i < N - 1; i++) begin
        w_shift_nx[i] = bus.s_first ? 1'b0 : r_shift[i+1];
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_done     = 1'b0;
    w_ferr_nx  = 1'b0;
    if (w_acc) begin
      unique case (r_state)
        IDLE: begin
          if (bus.s_first) begin
            if (N == 1) begin
              w_done = 1'b1;
            end else begin
              w_state_nx = ASSEMBLE;
              w_cnt_nx   = CNTW'(1);
            end
          end else begin
            w_ferr_nx = 1'b1;
          end
        end
        ASSEMBLE: begin
          if (bus.s_first) begin
            w_ferr_nx = 1'b1;
            if (N == 1) begin
              w_done     = 1'b1;
              w_state_nx = IDLE;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = CNTW'(1);
            end
          end else if (w_last) begin
            w_done     = 1'b1;
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNTW'(1);
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_shift <= w_shift_nx;
      r_ferr  <= w_ferr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {bus.s_cout, w_shift_nx};
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_mem[r_rp];
  assign count         = r_count;
  assign frame_err     = r_ferr;
  assign busy          = (r_state == ASSEMBLE);

endmodule

// File: tb/tb_serial_sum_collector.sv
// Randomized self-checking bench for serial_sum_collector.
// Reference model: bit array + word queue driven by the serial rules.
module tb_serial_sum_collector;
  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int CW    = 2;
  localparam int W     = 1 + (N + 1) + CW + 3;

  logic          clk;
  logic          rst;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          busy;

  serial_sum_collector_if #(.N(N)) bus ();

  serial_sum_collector #(
    .N(N), .DEPTH(DEPTH), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .count(count),
    .frame_err(frame_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [N:0]   m_q[$];
  bit   [N-1:0] m_bits;
  int           m_len;
  bit           m_ferr;

  logic [W-1:0] obs;
  assign obs = {bus.out_valid,
                bus.out_valid ? bus.out_data : {(N+1){1'b0}},
                count, frame_err, busy, bus.s_ready};

  function automatic bit m_rdy();
    return !(m_len == N - 1 && m_q.size() == DEPTH);
  endfunction

  function automatic logic [W-1:0] exp_vec();
    logic [N:0] d;
    d = (m_q.size() != 0) ? m_q[0] : '0;
    return {m_q.size() != 0, d, CW'(m_q.size()),
            m_ferr, m_len != 0, m_rdy()};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_bits = '0;
    m_len  = 0;
    m_ferr = 0;
  endfunction

  function automatic void model_step(bit v, bit b, bit f, bit c, bit o);
    bit         acc;
    bit         pop;
    bit         push;
    logic [N:0] w;
    acc  = v && m_rdy();
    pop  = (m_q.size() != 0) && o;
    push = 0;
    w    = '0;
    m_ferr = 0;
    if (acc) begin
      if (f) begin
        if (m_len != 0) m_ferr = 1;
        m_len = 0;
      end
      if (!f && m_len == 0) begin
        m_ferr = 1;
      end else begin
        m_bits[m_len] = b;
        m_len++;
        if (m_len == N) begin
          w     = {c, m_bits};
          push  = 1;
          m_len = 0;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(w);
  endfunction

  task automatic cyc(input bit v, input bit b, input bit f,
                     input bit c, input bit o);
    bus.s_valid   = v;
    bus.s_bit     = b;
    bus.s_first   = f;
    bus.s_cout    = c;
    bus.out_ready = o;
    @(posedge clk);
    model_step(v, b, f, c, o);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit c,
                           input bit o);
    for (int i = 0; i < N; i++) begin
      cyc(1'b1, w[i], i == 0, (i == N - 1) ? c : ~c, o);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] rv;
    rst = 1'b0;
    bus.s_valid = 0; bus.s_bit = 0; bus.s_first = 0;
    bus.s_cout = 0; bus.out_ready = 0;
    model_reset();
    #3;
    rv = {1'b0, {(N+1){1'b0}}, {CW{1'b0}}, 1'b0, 1'b0, 1'b1};
    n_tests++;
    if ({bus.out_valid, bus.out_data, count, frame_err, busy,
         bus.s_ready} !== rv) begin
      n_fail++;
      $display("FAIL reset_vals got=%h want=%h",
               {bus.out_valid, bus.out_data, count, frame_err, busy,
                bus.s_ready}, rv);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send_word(4'b0110, 1'b1, 1'b0);
    n_tests++;
    if (bus.out_data !== 5'b10110 || count !== 2'd1 ||
        bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_word got=%b/%0d want=10110/1",
               bus.out_data, count);
    end
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL basic_model got=%h want=%h", obs, exp_vec());
    end
    cyc(0, 0, 0, 0, 1);
    n_tests++;
    if (obs !== exp_vec() || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] w3;
    w3 = N'($urandom);
    send_word(4'b1111, 1'b1, 1'b0);
    send_word(4'b0001, 1'b0, 1'b0);
    n_tests++;
    if (count !== 2'd2 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL bp_full got=%0d/%h want=2/%h",
               count, obs, exp_vec());
    end
    for (int i = 0; i < N - 1; i++) begin
      cyc(1, w3[i], i == 0, 0, 0);
    end
    n_tests++;
    if (bus.s_ready !== 1'b0 || bus.out_data !== 5'b11111 ||
        obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL bp_stall got=%b/%b want=0/11111",
               bus.s_ready, bus.out_data);
    end
    cyc(1, w3[N-1], 0, 1, 1);
    n_tests++;
    if (bus.s_ready !== 1'b1 || count !== 2'd1 ||
        bus.out_data !== 5'b00001 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL bp_pop got=%b/%0d/%b want=1/1/00001",
               bus.s_ready, count, bus.out_data);
    end
    cyc(1, w3[N-1], 0, 1, 0);
    n_tests++;
    if (count !== 2'd2 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL bp_push got=%h want=%h", obs, exp_vec());
    end
    cyc(0, 0, 0, 0, 1);
    n_tests++;
    if (bus.out_data !== {1'b1, w3} || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL bp_third got=%b want=%b",
               bus.out_data, {1'b1, w3});
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_stream();
    logic [N-1:0] w;
    bit           c;
    for (int k = 0; k < 6; k++) begin
      w = N'($urandom);
      c = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        cyc(1, w[i], i == 0, (i == N - 1) ? c : ~c, 1);
        n_tests++;
        if (obs !== exp_vec() || count > 2'd1 ||
            bus.s_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream k=%0d i=%0d got=%h want=%h",
                   k, i, obs, exp_vec());
        end
      end
    end
    cyc(0, 0, 0, 0, 1);
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL stream_end got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_frame_err();
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    n_tests++;
    if (frame_err !== 1'b1 || busy !== 1'b1 ||
        obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL ferr_restart got=%b want=1", frame_err);
    end
    cyc(1, 0, 0, 1, 0);
    n_tests++;
    if (frame_err !== 1'b0 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL ferr_pulse got=%b want=0", frame_err);
    end
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0);
    n_tests++;
    if (bus.out_data !== 5'b01001 || count !== 2'd1 ||
        obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL ferr_word got=%b want=01001", bus.out_data);
    end
    cyc(1, 1, 0, 1, 0);
    n_tests++;
    if (frame_err !== 1'b1 || count !== 2'd1 || busy !== 1'b0 ||
        obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL ferr_idle got=%b/%0d want=1/1",
               frame_err, count);
    end
    cyc(0, 0, 0, 0, 1);
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL ferr_drain got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_midword();
    logic [N-1:0] w;
    w = N'($urandom);
    send_word(w, 1'b0, 1'b0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    n_tests++;
    if (busy !== 1'b1 || count !== 2'd1 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL rst_pre got=%h want=%h", obs, exp_vec());
    end
    bus.s_valid = 0;
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || count !== 2'd0 ||
        busy !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async got=%b/%0d/%b want=0/0/0",
               bus.out_valid, count, busy);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    send_word(4'b1011, 1'b1, 1'b0);
    n_tests++;
    if (bus.out_data !== 5'b11011 || count !== 2'd1 ||
        obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL rst_clean got=%b want=11011", bus.out_data);
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_push_pop();
    logic [N-1:0] a;
    logic [N-1:0] b;
    a = N'($urandom);
    b = ~a;
    send_word(a, 1'b1, 1'b0);
    for (int i = 0; i < N - 1; i++) begin
      cyc(1, b[i], i == 0, 1, 0);
    end
    n_tests++;
    if (bus.out_data !== {1'b1, a} || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL pp_head got=%b want=%b", bus.out_data, {1'b1, a});
    end
    cyc(1, b[N-1], 0, 0, 1);
    n_tests++;
    if (count !== 2'd1 || bus.out_data !== {1'b0, b} ||
        obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL pp_swap got=%0d/%b want=1/%b",
               count, bus.out_data, {1'b0, b});
    end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit v;
    bit f;
    int errs;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 4) != 0);
      f = ($urandom_range(0, 11) == 0) ||
          (m_len == 0 && $urandom_range(0, 5) != 0);
      cyc(v, 1'($urandom), f, 1'($urandom),
          ($urandom_range(0, 2) != 0));
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL random k=%0d got=%h want=%h",
                   k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_frame_err();
    test_reset_midword();
    test_push_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sum_collector.md
Name: serial_sum_collector

Overview:
- Downstream stage of the bit-serial adder: consumes its sum bitstream (LSB first) plus final carry-out.
- Reassembles each N-bit sum with carry into an (N+1)-bit parallel word.
- Buffers completed words in a small FIFO and presents them on a valid/ready output port to the parallel datapath.
- Detects and reports framing errors on the serial side.

Parameters:
N, 4, sum width in bits; a word is N serial bits plus 1 carry bit
DEPTH, 2, output FIFO depth in words; power of two, >= 2
CW, 2, width of FIFO occupancy count; log2(DEPTH)+1 when DEPTH=2

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
s_valid  input  1  serial bit present this cycle
s_bit  input  1  serial sum bit
s_first  input  1  marks the LSB (bit 0) of a new word; qualified by s_valid
s_cout  input  1  adder carry-out; sampled only with the word's last bit (bit N-1)
s_ready  output  1  collector accepts the serial bit this cycle
out_valid  output  1  FIFO head word available
out_ready  input  1  consumer takes head word
out_data  output  N+1  {carry, sum[N-1:0]} of FIFO head
count  output  CW  number of words held in FIFO
frame_err  output  1  one-cycle pulse on framing error
busy  output  1  a word is partially assembled

Behaviour:
- Reset (rst low, asynchronous): FSM=IDLE; bit counter=0; shift register=0; FIFO empty.
- Outputs under reset: out_valid=0, out_data=0, count=0, frame_err=0, busy=0, s_ready=1.
- A bit is accepted when s_valid && s_ready at the rising edge.
- FSM states:
  - IDLE: no partial word. Accepted bit with s_first=1 -> store as bit 0, cnt=1, go ASSEMBLE. If N=1, the word completes immediately.
  - IDLE, accepted bit with s_first=0: bit dropped, frame_err pulses next cycle, stay IDLE.
  - ASSEMBLE: accepted bit with s_first=0 is stored at position cnt; cnt increments.
  - ASSEMBLE, accepted bit at cnt=N-1: word completes. Push {s_cout, bits} into FIFO, cnt=0, go IDLE.
  - ASSEMBLE, accepted bit with s_first=1: partial word discarded, frame_err pulses. The bit is taken as bit 0 of a new word (cnt=1), stay ASSEMBLE.
- busy = (state==ASSEMBLE).
- Shift register: bits are shifted in at the MSB end and move right, so after N bits bit 0 sits at position 0. Carry is not stored until the last bit.
- Backpressure: s_ready = !(cnt==N-1 && FIFO full), independent of out_ready in that cycle, so there is no combinational path from out_ready to s_ready.
  - Non-last bits are always accepted.
- FIFO:
  - Read/write pointers with wrap-around modulo DEPTH; count tracks occupancy.
  - out_valid = (count != 0); out_data = entry at the read pointer, registered storage with no bypass.
  - A pushed word is visible on out_data one cycle after the final bit is accepted.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle (possible when not full): count unchanged, both pointers advance.
  - Pop on empty is ignored. Overflow is impossible by construction of s_ready.
  - out_data holds its value while out_valid && !out_ready.
- Reset mid-word or with FIFO occupied: all contents are lost, state returns to reset values immediately.
- frame_err is registered: exactly one cycle high per error, no accumulation.

Test Plan:
- N=4, reset deasserted, feed bits 0,1,1,0 (first on bit 0) with s_cout=1 on bit 3 -> one cycle later out_valid=1, out_data=5'b10110, count=1.
- Two back-to-back words 1111/c=1 and 0001/c=0, out_ready=0 -> count=2, third word's bits 0-2 accepted, s_ready=0 at bit 3. Then pulse out_ready -> 5'b11111 popped, s_ready=1, third word pushed, count=2.
- Continuous out_ready=1 with words streaming every 4 cycles -> each word appears once, in order, count never exceeds 1, no s_ready drop.
- Send s_first=1 at cnt=2 -> frame_err high one cycle, earlier 2 bits discarded, next 4 bits form a correct word. Lone bit with s_first=0 in IDLE -> frame_err, no push.
- Assert rst low mid-word (cnt=2) with count=1 -> out_valid=0, count=0, busy=0 asynchronously. A following clean word is assembled correctly.
- Simultaneous push and pop at count=1 -> count stays 1, out_data switches to the new word the next cycle.
